dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter REF_PERIOD, default 8'd96, number of DRAM cycles between refresh requests.
REQ-002 clk  in  1  system clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 c0, c1, c2, c3  in  1 each  one-hot phase strobes; one DRAM cycle = c0..c3 (4 clk).
REQ-005 cpu_req  in  1  CPU requests the next DRAM cycle.
REQ-006 cpu_rnw  in  1  1 = read, 0 = write.
REQ-007 cpu_addr  in  21  CPU word address.
REQ-008 cpu_wrbsel  in  1  write byte select: 0 = low byte, 1 = high byte.
REQ-009 cpu_wrdata  in  8  CPU write byte.
REQ-010 cpu_next  out  1  next DRAM cycle is available to the CPU.
REQ-011 cpu_rddata  out  16  registered read word.
REQ-012 cpu_strobe  out  1  one-clk pulse when cpu_rddata updates (cache write enable).
REQ-013 cpu_latch  out  1  cpu_rddata holds data of the current CPU read.
REQ-014 vid_req  in  1  video requests the next DRAM cycle.
REQ-015 vid_addr  in  21  video word address.
REQ-016 vid_strobe  out  1  one-clk pulse, video read word valid on vid_rddata.
REQ-017 vid_rddata  out  16  registered video read word.
REQ-018 dram_req  out  1  DRAM cycle active.
REQ-019 dram_rnw, dram_rfsh  out  1 each  read/write select; refresh cycle.
REQ-020 dram_addr  out  21  DRAM word address.
REQ-021 dram_bsel  out  2  byte enables {hi, lo}.
REQ-022 dram_wrdata  out  16  write word.
REQ-023 dram_rddata  in  16  read data, valid at c2 of a read cycle.

Function
REQ-024 Cycle type register cyc SHALL take one of NONE, RFSH, VID, CPU_RD, CPU_WR; it SHALL update only on the posedge where c3=1, selecting the next cycle.
REQ-025 Priority at c3: ref_pend -> RFSH; else vid_req -> VID; else cpu_req -> CPU_RD/CPU_WR per cpu_rnw; else NONE.
REQ-026 cpu_next SHALL equal !ref_pend && !vid_req (combinational); a CPU grant occurs exactly when c3 && cpu_req && cpu_next.
REQ-027 On grant, dram_addr, dram_rnw, dram_bsel, dram_wrdata, dram_rfsh SHALL be registered at the same c3 edge and held constant for the whole following cycle.
REQ-028 dram_req SHALL be 1 for all 4 clk of any cycle with cyc != NONE, and 0 otherwise.
REQ-029 CPU_RD: dram_bsel=2'b11; CPU_WR: dram_bsel=cpu_wrbsel ? 2'b10 : 2'b01, dram_wrdata={cpu_wrdata, cpu_wrdata}; VID: read, bsel 2'b11; RFSH: dram_rfsh=1, bsel 2'b00, dram_addr unchanged.
REQ-030 At the posedge where c2=1 and cyc=CPU_RD: cpu_rddata<=dram_rddata, cpu_strobe<=1, cpu_latch<=1; cpu_strobe SHALL clear at the next edge (exactly 1 clk).
REQ-031 cpu_latch SHALL clear at the posedge where c2=1 and cyc!=CPU_RD; it SHALL be high for 4 clk after an isolated CPU read and stay high across back-to-back CPU reads.
REQ-032 At the posedge where c2=1 and cyc=VID: vid_rddata<=dram_rddata, vid_strobe pulses 1 clk.
REQ-033 CPU_WR SHALL produce no cpu_strobe and SHALL clear cpu_latch at its c2.
REQ-034 Refresh counter, 8 bits, SHALL increment on every c3 and, on reaching REF_PERIOD-1, wrap to 0 and set ref_pend; ref_pend SHALL clear on the c3 edge that grants RFSH.
REQ-035 Counter wrap and RFSH grant on the same c3 edge: ref_pend SHALL remain 1 (new request wins over clear).
REQ-036 A CPU request denied at c3 (cpu_next=0) SHALL be neither lost nor latched: it is re-evaluated from live cpu_req at the next c3.
REQ-037 cpu_req, cpu_rnw, cpu_addr changes between c3 edges SHALL NOT affect the cycle in progress.

Reset
REQ-038 With rst=1 at a posedge: cyc=NONE, dram_req=0, dram_rnw=1, dram_rfsh=0, dram_bsel=0, dram_addr=0, dram_wrdata=0, cpu_rddata=0, vid_rddata=0, cpu_strobe=0, cpu_latch=0, vid_strobe=0, refresh counter=0, ref_pend=0.
REQ-039 rst mid-cycle SHALL abort the cycle immediately (dram_req=0 next clk) with no strobe generated; arbitration resumes at the first c3 after rst deasserts.

Verification
REQ-040 Idle, cpu_req=1, rnw=1, addr=21'h012345, dram_rddata=16'hA55A -> dram_req for 4 clk, cpu_rddata=16'hA55A, cpu_strobe 1 clk at c3, cpu_latch 4 clk.
REQ-041 CPU write, wrbsel=1, wrdata=8'h3C -> dram_bsel=2'b10, dram_wrdata=16'h3C3C, dram_rnw=0, no cpu_strobe.
REQ-042 vid_req and cpu_req both 1 at c3 -> cpu_next=0, VID cycle, vid_strobe 1 clk; CPU granted next c3 once vid_req=0.
REQ-043 REF_PERIOD=4, continuous cpu_req -> every 4th cycle is RFSH (dram_rfsh=1, bsel 2'b00), cpu_next=0 during that c3.
REQ-044 Three back-to-back CPU reads -> three cpu_strobe pulses spaced 4 clk, cpu_latch continuously 1.
REQ-045 rst asserted at c1 of a CPU read -> dram_req=0 next clk, no cpu_strobe, all outputs at reset values.

Source files
------------

// File: rtl/dram_arbiter.sv
// DRAM cycle arbiter: one DRAM cycle per c0..c3 phase group, shared between
// refresh, video and CPU with fixed priority, plus registered read-data capture.
module dram_arbiter #(
  parameter logic [7:0] REF_PERIOD = 8'd96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0,
  input  logic        c1,
  input  logic        c2,
  input  logic        c3,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic        cpu_wrbsel,
  input  logic [7:0]  cpu_wrdata,
  output logic        cpu_next,
  output logic [15:0] cpu_rddata,
  output logic        cpu_strobe,
  output logic        cpu_latch,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_strobe,
  output logic [15:0] vid_rddata,
  output logic        dram_req,
  output logic        dram_rnw,
  output logic        dram_rfsh,
  output logic [20:0] dram_addr,
  output logic [1:0]  dram_bsel,
  output logic [15:0] dram_wrdata,
  input  logic [15:0] dram_rddata
);

  localparam logic [2:0] CYC_NONE   = 3'd0;
  localparam logic [2:0] CYC_RFSH   = 3'd1;
  localparam logic [2:0] CYC_VID    = 3'd2;
  localparam logic [2:0] CYC_CPU_RD = 3'd3;
  localparam logic [2:0] CYC_CPU_WR = 3'd4;

  logic [2:0]  cyc_q, cyc_d;
  logic [7:0]  ref_cnt_q, ref_cnt_d;
  logic        ref_pend_q, ref_pend_d;
  logic        rnw_q, rnw_d;
  logic        rfsh_q, rfsh_d;
  logic [20:0] addr_q, addr_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [15:0] wrdata_q, wrdata_d;
  logic [15:0] cpu_rddata_q, cpu_rddata_d;
  logic [15:0] vid_rddata_q, vid_rddata_d;
  logic        cpu_strobe_q, cpu_strobe_d;
  logic        cpu_latch_q, cpu_latch_d;
  logic        vid_strobe_q, vid_strobe_d;

  // A phase only counts when the strobes are cleanly one-hot, so a glitch that
  // raises two strobes at once cannot start or capture a cycle.
  logic phase_c2, phase_c3;
  assign phase_c2 = c2 & ~(c0 | c1 | c3);
  assign phase_c3 = c3 & ~(c0 | c1 | c2);

  assign cpu_next = !ref_pend_q && !vid_req;

  always_comb begin
    // NOTE: every _d defaults to its _q (strobes to 0) so no branch leaves a
    // variable unassigned; that is what keeps this block free of latches.
    cyc_d        = cyc_q;
    ref_cnt_d    = ref_cnt_q;
    ref_pend_d   = ref_pend_q;
    rnw_d        = rnw_q;
    rfsh_d       = rfsh_q;
    addr_d       = addr_q;
    bsel_d       = bsel_q;
    wrdata_d     = wrdata_q;
    cpu_rddata_d = cpu_rddata_q;
    vid_rddata_d = vid_rddata_q;
    cpu_strobe_d = 1'b0;
    cpu_latch_d  = cpu_latch_q;
    vid_strobe_d = 1'b0;

    if (phase_c3) begin
      ref_cnt_d = ref_cnt_q + 8'd1;
      if (ref_pend_q) begin
        cyc_d      = CYC_RFSH;
        rfsh_d     = 1'b1;
        rnw_d      = 1'b1;
        bsel_d     = 2'b00;
        ref_pend_d = 1'b0;
      end else if (vid_req) begin
        cyc_d  = CYC_VID;
        rfsh_d = 1'b0;
        rnw_d  = 1'b1;
        bsel_d = 2'b11;
        addr_d = vid_addr;
      end else if (cpu_req) begin
        rfsh_d = 1'b0;
        addr_d = cpu_addr;
        if (cpu_rnw) begin
          cyc_d  = CYC_CPU_RD;
          rnw_d  = 1'b1;
          bsel_d = 2'b11;
        end else begin
          cyc_d    = CYC_CPU_WR;
          rnw_d    = 1'b0;
          bsel_d   = cpu_wrbsel ? 2'b10 : 2'b01;
          wrdata_d = {cpu_wrdata, cpu_wrdata};
        end
      end else begin
        cyc_d  = CYC_NONE;
        rfsh_d = 1'b0;
        rnw_d  = 1'b1;
        bsel_d = 2'b00;
      end
      // Placed after the grant so a wrap on the granting edge keeps the request.
      if (ref_cnt_q == REF_PERIOD - 8'd1) begin
        ref_cnt_d  = 8'd0;
        ref_pend_d = 1'b1;
      end
    end

    if (phase_c2) begin
      if (cyc_q == CYC_CPU_RD) begin
        cpu_rddata_d = dram_rddata;
        cpu_strobe_d = 1'b1;
        cpu_latch_d  = 1'b1;
      end else begin
        cpu_latch_d = 1'b0;
      end
      if (cyc_q == CYC_VID) begin
        vid_rddata_d = dram_rddata;
        vid_strobe_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q        <= CYC_NONE;
      ref_cnt_q    <= 8'd0;
      ref_pend_q   <= 1'b0;
      rnw_q        <= 1'b1;
      rfsh_q       <= 1'b0;
      addr_q       <= 21'd0;
      bsel_q       <= 2'b00;
      wrdata_q     <= 16'd0;
      cpu_rddata_q <= 16'd0;
      vid_rddata_q <= 16'd0;
      cpu_strobe_q <= 1'b0;
      cpu_latch_q  <= 1'b0;
      vid_strobe_q <= 1'b0;
    end else begin
      cyc_q        <= cyc_d;
      ref_cnt_q    <= ref_cnt_d;
      ref_pend_q   <= ref_pend_d;
      rnw_q        <= rnw_d;
      rfsh_q       <= rfsh_d;
      addr_q       <= addr_d;
      bsel_q       <= bsel_d;
      wrdata_q     <= wrdata_d;
      cpu_rddata_q <= cpu_rddata_d;
      vid_rddata_q <= vid_rddata_d;
      cpu_strobe_q <= cpu_strobe_d;
      cpu_latch_q  <= cpu_latch_d;
      vid_strobe_q <= vid_strobe_d;
    end
  end

  assign dram_req    = (cyc_q != CYC_NONE);
  assign dram_rnw    = rnw_q;
  assign dram_rfsh   = rfsh_q;
  assign dram_addr   = addr_q;
  assign dram_bsel   = bsel_q;
  assign dram_wrdata = wrdata_q;
  assign cpu_rddata  = cpu_rddata_q;
  assign cpu_strobe  = cpu_strobe_q;
  assign cpu_latch   = cpu_latch_q;
  assign vid_rddata  = vid_rddata_q;
  assign vid_strobe  = vid_strobe_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random traffic, all checked
// against a per-DRAM-cycle transaction model of grants, refresh and read data.
module tb_dram_arbiter;

  localparam int REF_P  = 4;
  localparam int K_NONE = 0;
  localparam int K_RFSH = 1;
  localparam int K_VID  = 2;
  localparam int K_RD   = 3;
  localparam int K_WR   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c0, c1, c2, c3;
  logic        cpu_req = 1'b0, cpu_rnw = 1'b1, cpu_wrbsel = 1'b0;
  logic [20:0] cpu_addr = 21'd0;
  logic [7:0]  cpu_wrdata = 8'd0;
  logic        cpu_next, cpu_strobe, cpu_latch;
  logic [15:0] cpu_rddata;
  logic        vid_req = 1'b0;
  logic [20:0] vid_addr = 21'd0;
  logic        vid_strobe;
  logic [15:0] vid_rddata;
  logic        dram_req, dram_rnw, dram_rfsh;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;
  logic [15:0] dram_wrdata;
  logic [15:0] dram_rddata = 16'd0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int phase     = 0;

  // Transaction-level model state
  bit          m_pend;
  int          m_edges;
  logic [20:0] m_addr;
  bit          m_latch;
  logic [15:0] m_cpu_data, m_vid_data;

  dram_arbiter #(.REF_PERIOD(8'd4)) dut (
    .clk(clk), .rst(rst), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next),
    .cpu_rddata(cpu_rddata), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_strobe(vid_strobe),
    .vid_rddata(vid_rddata), .dram_req(dram_req), .dram_rnw(dram_rnw),
    .dram_rfsh(dram_rfsh), .dram_addr(dram_addr), .dram_bsel(dram_bsel),
    .dram_wrdata(dram_wrdata), .dram_rddata(dram_rddata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_phase();
    c0 = (phase == 0);
    c1 = (phase == 1);
    c2 = (phase == 2);
    c3 = (phase == 3);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    phase = (phase + 1) % 4;
    set_phase();
  endtask

  task automatic model_reset();
    m_pend     = 1'b0;
    m_edges    = 0;
    m_addr     = 21'd0;
    m_latch    = 1'b0;
    m_cpu_data = 16'd0;
    m_vid_data = 16'd0;
  endtask

  function automatic logic [76:0] out_vec();
    return {dram_req, dram_rnw, dram_rfsh, dram_bsel, dram_addr, dram_wrdata,
            cpu_rddata, vid_rddata, cpu_strobe, cpu_latch, vid_strobe};
  endfunction

  // Runs one DRAM cycle starting in the c3 phase; ends in the next c3 phase.
  task automatic run_cycle(input logic req, input logic rnw, input logic [20:0] addr,
                           input logic wbs, input logic [7:0] wd, input logic vreq,
                           input logic [20:0] vaddr, input logic [15:0] rd,
                           output int kind);
    logic       exp_next;
    logic [1:0] exp_bsel;
    cpu_req = req; cpu_rnw = rnw; cpu_addr = addr; cpu_wrbsel = wbs;
    cpu_wrdata = wd; vid_req = vreq; vid_addr = vaddr;
    #1;
    exp_next = !m_pend && !vreq;
    total_cnt++;
    if (cpu_next !== exp_next)
      $display("FAIL cpu_next at c3: got %b expected %b", cpu_next, exp_next);
    else pass_cnt++;

    if (m_pend) kind = K_RFSH;
    else if (vreq) kind = K_VID;
    else if (req) kind = rnw ? K_RD : K_WR;
    else kind = K_NONE;
    if (kind == K_RFSH) m_pend = 1'b0;
    m_edges++;
    if (m_edges % REF_P == 0) m_pend = 1'b1;
    if (kind == K_VID) m_addr = vaddr;
    else if (kind == K_RD || kind == K_WR) m_addr = addr;
    exp_bsel = (kind == K_RFSH) ? 2'b00 : (kind == K_WR) ? (wbs ? 2'b10 : 2'b01) : 2'b11;

    step();
    // Requests changing mid-cycle must not disturb the cycle in progress.
    cpu_req = 1'($urandom); cpu_rnw = 1'($urandom); cpu_addr = 21'($urandom);
    cpu_wrbsel = 1'($urandom); cpu_wrdata = 8'($urandom);
    vid_req = 1'($urandom); vid_addr = 21'($urandom);

    for (int p = 0; p < 4; p++) begin
      dram_rddata = (p == 2) ? rd : 16'($urandom);
      total_cnt++;
      if (dram_req !== (kind != K_NONE))
        $display("FAIL dram_req p%0d: got %b expected %b", p, dram_req, kind != K_NONE);
      else pass_cnt++;
      if (kind != K_NONE) begin
        total_cnt++;
        if (dram_rfsh !== (kind == K_RFSH))
          $display("FAIL dram_rfsh p%0d: got %b expected %b", p, dram_rfsh, kind == K_RFSH);
        else pass_cnt++;
        total_cnt++;
        if (dram_bsel !== exp_bsel)
          $display("FAIL dram_bsel p%0d: got %b expected %b", p, dram_bsel, exp_bsel);
        else pass_cnt++;
        total_cnt++;
        if (dram_addr !== m_addr)
          $display("FAIL dram_addr p%0d: got %h expected %h", p, dram_addr, m_addr);
        else pass_cnt++;
        if (kind != K_RFSH) begin
          total_cnt++;
          if (dram_rnw !== (kind != K_WR))
            $display("FAIL dram_rnw p%0d: got %b expected %b", p, dram_rnw, kind != K_WR);
          else pass_cnt++;
        end
        if (kind == K_WR) begin
          total_cnt++;
          if (dram_wrdata !== {wd, wd})
            $display("FAIL dram_wrdata p%0d: got %h expected %h", p, dram_wrdata, {wd, wd});
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (cpu_strobe !== (p == 3 && kind == K_RD))
        $display("FAIL cpu_strobe p%0d: got %b expected %b", p, cpu_strobe, p == 3 && kind == K_RD);
      else pass_cnt++;
      total_cnt++;
      if (vid_strobe !== (p == 3 && kind == K_VID))
        $display("FAIL vid_strobe p%0d: got %b expected %b", p, vid_strobe, p == 3 && kind == K_VID);
      else pass_cnt++;
      total_cnt++;
      if (cpu_latch !== ((p == 3) ? (kind == K_RD) : m_latch))
        $display("FAIL cpu_latch p%0d: got %b expected %b", p, cpu_latch,
                 (p == 3) ? (kind == K_RD) : m_latch);
      else pass_cnt++;
      total_cnt++;
      if (cpu_rddata !== ((p == 3 && kind == K_RD) ? rd : m_cpu_data))
        $display("FAIL cpu_rddata p%0d: got %h expected %h", p, cpu_rddata,
                 (p == 3 && kind == K_RD) ? rd : m_cpu_data);
      else pass_cnt++;
      total_cnt++;
      if (vid_rddata !== ((p == 3 && kind == K_VID) ? rd : m_vid_data))
        $display("FAIL vid_rddata p%0d: got %h expected %h", p, vid_rddata,
                 (p == 3 && kind == K_VID) ? rd : m_vid_data);
      else pass_cnt++;
      if (p < 3) step();
    end
    m_latch = (kind == K_RD);
    if (kind == K_RD) m_cpu_data = rd;
    if (kind == K_VID) m_vid_data = rd;
  endtask

  // Idle until a refresh has just been granted, leaving three refresh-free cycles.
  task automatic wait_after_rfsh();
    int k;
    for (int i = 0; i < 2 * REF_P + 2; i++) begin
      run_cycle(1'b0, 1'b1, 21'd0, 1'b0, 8'd0, 1'b0, 21'd0, 16'($urandom), k);
      if (k == K_RFSH) break;
    end
  endtask

  task automatic test_reset();
    logic [76:0] exp_v;
    exp_v = {1'b0, 1'b1, 1'b0, 2'b00, 21'd0, 16'd0, 16'd0, 16'd0, 3'b000};
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step();
    total_cnt++;
    if (out_vec() !== exp_v)
      $display("FAIL reset_outputs: got %h expected %h", out_vec(), exp_v);
    else pass_cnt++;
    total_cnt++;
    if (cpu_next !== 1'b1)
      $display("FAIL reset_cpu_next: got %b expected 1", cpu_next);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 4 && phase != 3; i++) step();
    model_reset();
  endtask

  task automatic test_cpu_read();
    int k;
    wait_after_rfsh();
    run_cycle(1'b1, 1'b1, 21'h012345, 1'b0, 8'h00, 1'b0, 21'd0, 16'hA55A, k);
    total_cnt++;
    if (cpu_rddata !== 16'hA55A)
      $display("FAIL cpu_read_data: got %h expected a55a", cpu_rddata);
    else pass_cnt++;
    run_cycle(1'b0, 1'b1, 21'd0, 1'b0, 8'h00, 1'b0, 21'd0, 16'h0000, k);
  endtask

  task automatic test_cpu_write();
    int k;
    wait_after_rfsh();
    run_cycle(1'b1, 1'b0, 21'h1ABCDE, 1'b1, 8'h3C, 1'b0, 21'd0, 16'h5555, k);
    total_cnt++;
    if ({dram_bsel, dram_wrdata, dram_rnw} !== {2'b10, 16'h3C3C, 1'b0})
      $display("FAIL cpu_write_fields: got %b/%h/%b expected 10/3c3c/0",
               dram_bsel, dram_wrdata, dram_rnw);
    else pass_cnt++;
    run_cycle(1'b1, 1'b0, 21'h000777, 1'b0, 8'hC3, 1'b0, 21'd0, 16'h1234, k);
  endtask

  task automatic test_vid_priority();
    int k;
    wait_after_rfsh();
    run_cycle(1'b1, 1'b1, 21'h0000AA, 1'b0, 8'h00, 1'b1, 21'h155555, 16'hBEEF, k);
    total_cnt++;
    if (vid_rddata !== 16'hBEEF)
      $display("FAIL vid_read_data: got %h expected beef", vid_rddata);
    else pass_cnt++;
    run_cycle(1'b1, 1'b1, 21'h0000AA, 1'b0, 8'h00, 1'b0, 21'd0, 16'hC0DE, k);
    total_cnt++;
    if ({dram_addr, cpu_rddata} !== {21'h0000AA, 16'hC0DE})
      $display("FAIL cpu_after_vid: got %h/%h expected 0000aa/c0de", dram_addr, cpu_rddata);
    else pass_cnt++;
  endtask

  task automatic test_refresh();
    int k;
    int seen = 0;
    for (int i = 0; i < 12; i++) begin
      run_cycle(1'b1, 1'b1, 21'($urandom), 1'b0, 8'd0, 1'b0, 21'd0, 16'($urandom), k);
      if (dram_rfsh === 1'b1) seen++;
    end
    total_cnt++;
    if (seen !== 3)
      $display("FAIL refresh_count: got %0d expected 3", seen);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int k;
    logic [15:0] d;
    wait_after_rfsh();
    for (int i = 0; i < 3; i++) begin
      d = 16'h1000 + 16'(i * 16'h0111);
      run_cycle(1'b1, 1'b1, 21'(i + 1), 1'b0, 8'd0, 1'b0, 21'd0, d, k);
      total_cnt++;
      if ({cpu_latch, cpu_rddata} !== {1'b1, d})
        $display("FAIL b2b_read%0d: got %b/%h expected 1/%h", i, cpu_latch, cpu_rddata, d);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [76:0] exp_v;
    exp_v = {1'b0, 1'b1, 1'b0, 2'b00, 21'd0, 16'd0, 16'd0, 16'd0, 3'b000};
    wait_after_rfsh();
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h0ABCDE; vid_req = 1'b0;
    step();
    total_cnt++;
    if (dram_req !== 1'b1)
      $display("FAIL mid_rst_started: got %b expected 1", dram_req);
    else pass_cnt++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if (out_vec() !== exp_v)
      $display("FAIL mid_rst_outputs: got %h expected %h", out_vec(), exp_v);
    else pass_cnt++;
    dram_rddata = 16'hDEAD;
    step();
    total_cnt++;
    if ({dram_req, cpu_strobe, cpu_latch, cpu_rddata} !== {3'b000, 16'd0})
      $display("FAIL mid_rst_no_strobe: got %b%b%b/%h expected 000/0000",
               dram_req, cpu_strobe, cpu_latch, cpu_rddata);
    else pass_cnt++;
    model_reset();
  endtask

  task automatic test_random();
    int k;
    for (int i = 0; i < 150; i++)
      run_cycle(1'($urandom), 1'($urandom), 21'($urandom), 1'($urandom), 8'($urandom),
                ($urandom_range(2) == 0), 21'($urandom), 16'($urandom), k);
  endtask

  initial begin
    set_phase();
    model_reset();
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_vid_priority();
    test_refresh();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
